// File: rtl/l2_config_and_types.sv
// Shared types and constants for the L2 atomic requester and its local reservation shadow.
package l2_config_and_types;

  localparam int L2_NUM_PORTS = 4;
  localparam int L2_ID_W      = (L2_NUM_PORTS > 1) ? $clog2(L2_NUM_PORTS) : 1;
  localparam int L2_ADDR_W    = 30;
  localparam int L2_DATA_W    = 32;

  typedef enum logic [1:0] {
    L2_OP_LR  = 2'b00,
    L2_OP_SC  = 2'b01,
    L2_OP_RMW = 2'b10
  } l2_atomic_op_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'b00,
    ST_ISSUE     = 2'b01,
    ST_WAIT_RESP = 2'b10,
    ST_RESPOND   = 2'b11
  } l2_req_state_t;

  typedef struct packed {
    logic lr;
    logic sc;
    logic store;
  } l2_flags_t;

  // Unknown encodings decode to no flags at all.
  function automatic l2_flags_t op_flags(input l2_atomic_op_t op);
    l2_flags_t f;
    f = '0;
    case (op)
      L2_OP_LR:  f.lr = 1'b1;
      L2_OP_SC:  begin f.sc = 1'b1; f.store = 1'b1; end
      L2_OP_RMW: f.store = 1'b1;
      default:   f = '0;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/l2_local_reservation.sv
// Local shadow of this port's L2 reservation; lets doomed store-conditionals fail without an L2 trip.
module l2_local_reservation
  import l2_config_and_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_i,
  input  logic [L2_ADDR_W-1:0] set_addr_i,
  input  logic                 sc_clr_i,
  input  logic                 rmw_i,
  input  logic [L2_ADDR_W-1:0] rmw_addr_i,
  input  logic                 inv_valid_i,
  input  logic [L2_ADDR_W-1:0] inv_addr_i,
  input  logic [L2_ADDR_W-1:0] chk_addr_i,
  output logic                 hit_o
);

  logic                 valid_q, valid_d;
  logic [L2_ADDR_W-1:0] addr_q, addr_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    if (sc_clr_i ||
        (rmw_i && (rmw_addr_i == addr_q)) ||
        (inv_valid_i && (inv_addr_i == addr_q))) begin
      valid_d = 1'b0;
    end
    // A store to the very line being reserved in the same cycle kills the new reservation.
    if (set_i) begin
      addr_d  = set_addr_i;
      valid_d = !(inv_valid_i && (inv_addr_i == set_addr_i));
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
    end
  end

  assign hit_o = valid_q && (addr_q == chk_addr_i);

endmodule

// File: rtl/l2_atomic_requester.sv
// Per-port LR/SC/RMW initiator into the L2 arbiter; optional SC filter under L2_SC_LOCAL_FILTER_EN.
// state        | meaning
// IDLE         | accepting a core request
// ISSUE        | l2_req_valid held with latched fields until arbiter accepts
// WAIT_RESP    | waiting for read data (LR/RMW) or SC outcome
// RESPOND      | one-cycle resp_valid strobe
module l2_atomic_requester
  import l2_config_and_types::*;
#(
  parameter int PORT_ID = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic [L2_ADDR_W-1:0] req_addr,
  input  l2_atomic_op_t        req_op,
  input  logic [L2_DATA_W-1:0] req_data,
  output logic                 resp_valid,
  output logic [L2_DATA_W-1:0] resp_data,
  output logic                 l2_req_valid,
  input  logic                 l2_req_ready,
  output logic [L2_ADDR_W-1:0] l2_addr,
  output logic [L2_ID_W-1:0]   l2_id,
  output logic                 l2_lr,
  output logic                 l2_sc,
  output logic                 l2_store,
  output logic [L2_DATA_W-1:0] l2_wdata,
  input  logic                 l2_rd_valid,
  input  logic [L2_DATA_W-1:0] l2_rd_data,
  input  logic                 l2_sc_valid,
  input  logic                 l2_sc_abort,
  input  logic                 inv_valid,
  input  logic [L2_ADDR_W-1:0] inv_addr
);

  l2_req_state_t        state_q, state_d;
  l2_atomic_op_t        op_q;
  logic [L2_ADDR_W-1:0] addr_q;
  logic [L2_DATA_W-1:0] wdata_q;
  l2_flags_t            flags_q;
  logic [L2_DATA_W-1:0] resp_data_q, resp_data_d;

  logic accept;
  logic filtered;
  logic shadow_hit;
  logic lr_done;

  always_comb begin
    state_d     = state_q;
    accept      = 1'b0;
    filtered    = 1'b0;
    resp_data_d = resp_data_q;
    lr_done     = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          accept = 1'b1;
          if ((req_op == L2_OP_SC) && !shadow_hit) begin
            filtered    = 1'b1;
            resp_data_d = 32'd1;
            state_d     = ST_RESPOND;
          end else begin
            state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (l2_req_ready) state_d = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        // Returns of the other kind belong to nobody here and are dropped.
        if (op_q == L2_OP_SC) begin
          if (l2_sc_valid) begin
            resp_data_d = {31'b0, l2_sc_abort};
            state_d     = ST_RESPOND;
          end
        end else if (l2_rd_valid) begin
          resp_data_d = l2_rd_data;
          lr_done     = (op_q == L2_OP_LR);
          state_d     = ST_RESPOND;
        end
      end
      ST_RESPOND: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      op_q        <= L2_OP_LR;
      addr_q      <= '0;
      wdata_q     <= '0;
      flags_q     <= '0;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      resp_data_q <= resp_data_d;
      if (accept && !filtered) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_data;
        flags_q <= op_flags(req_op);
      end
    end
  end

`ifdef L2_SC_LOCAL_FILTER_EN
  l2_local_reservation u_resv (
    .clk        (clk),
    .rst        (rst),
    .set_i      (lr_done),
    .set_addr_i (addr_q),
    .sc_clr_i   (accept && (req_op == L2_OP_SC)),
    .rmw_i      (accept && (req_op == L2_OP_RMW)),
    .rmw_addr_i (req_addr),
    .inv_valid_i(inv_valid),
    .inv_addr_i (inv_addr),
    .chk_addr_i (req_addr),
    .hit_o      (shadow_hit)
  );
`else
  // Without the shadow every SC goes to L2, which owns the reservation.
  logic unused_filter_inputs;
  assign unused_filter_inputs = ^{inv_valid, inv_addr, lr_done};
  assign shadow_hit = 1'b1;
`endif

  assign req_ready    = (state_q == ST_IDLE);
  assign resp_valid   = (state_q == ST_RESPOND);
  assign resp_data    = resp_data_q;
  assign l2_req_valid = (state_q == ST_ISSUE);
  assign l2_addr      = addr_q;
  assign l2_wdata     = wdata_q;
  assign l2_id        = PORT_ID[L2_ID_W-1:0];
  assign l2_lr        = flags_q.lr;
  assign l2_sc        = flags_q.sc;
  assign l2_store     = flags_q.store;

endmodule

// File: tb/tb_l2_atomic_requester.sv
// Directed self-checking bench for l2_atomic_requester; filter cases run when L2_SC_LOCAL_FILTER_EN is defined.
module tb_l2_atomic_requester;
  import l2_config_and_types::*;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [29:0]   req_addr = '0;
  l2_atomic_op_t req_op = L2_OP_LR;
  logic [31:0]   req_data = '0;
  logic          resp_valid;
  logic [31:0]   resp_data;
  logic          l2_req_valid;
  logic          l2_req_ready = 1'b0;
  logic [29:0]   l2_addr;
  logic [L2_ID_W-1:0] l2_id;
  logic          l2_lr, l2_sc, l2_store;
  logic [31:0]   l2_wdata;
  logic          l2_rd_valid = 1'b0;
  logic [31:0]   l2_rd_data = '0;
  logic          l2_sc_valid = 1'b0;
  logic          l2_sc_abort = 1'b0;
  logic          inv_valid = 1'b0;
  logic [29:0]   inv_addr = '0;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  l2_atomic_requester #(.PORT_ID(2)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_op(req_op), .req_data(req_data),
    .resp_valid(resp_valid), .resp_data(resp_data),
    .l2_req_valid(l2_req_valid), .l2_req_ready(l2_req_ready),
    .l2_addr(l2_addr), .l2_id(l2_id), .l2_lr(l2_lr), .l2_sc(l2_sc),
    .l2_store(l2_store), .l2_wdata(l2_wdata),
    .l2_rd_valid(l2_rd_valid), .l2_rd_data(l2_rd_data),
    .l2_sc_valid(l2_sc_valid), .l2_sc_abort(l2_sc_abort),
    .inv_valid(inv_valid), .inv_addr(inv_addr)
  );

  typedef struct {
    l2_atomic_op_t op;
    logic [29:0]   addr;
    logic [31:0]   wdata;
    int            stall;
    logic [31:0]   rdata;
    logic          abort;
    bit            wrong_kind;
    logic          exp_lr, exp_sc, exp_store;
    logic [31:0]   exp_resp;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h expected=%h @%0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk_fields(input string nm, input vec_t v);
    chk({nm, " l2_req_valid"}, 32'(l2_req_valid), 32'd1);
    chk({nm, " l2_addr"}, 32'(l2_addr), 32'(v.addr));
    chk({nm, " l2_wdata"}, l2_wdata, v.wdata);
    chk({nm, " l2_lr"}, 32'(l2_lr), 32'(v.exp_lr));
    chk({nm, " l2_sc"}, 32'(l2_sc), 32'(v.exp_sc));
    chk({nm, " l2_store"}, 32'(l2_store), 32'(v.exp_store));
    chk({nm, " l2_id"}, 32'(l2_id), 32'd2);
  endtask

  task automatic run_op(input string nm, input vec_t v);
    @(negedge clk);
    chk({nm, " req_ready_idle"}, 32'(req_ready), 32'd1);
    req_valid = 1'b1; req_op = v.op; req_addr = v.addr; req_data = v.wdata;
    @(negedge clk);
    // Scramble the core side to prove the l2 fields come from latched copies.
    req_valid = 1'b0; req_addr = ~v.addr; req_data = ~v.wdata; req_op = L2_OP_RMW;
    chk({nm, " req_ready_busy"}, 32'(req_ready), 32'd0);
    chk_fields({nm, " issue"}, v);
    for (int k = 0; k < v.stall; k++) begin
      @(negedge clk);
      chk_fields({nm, " stall"}, v);
    end
    l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    chk({nm, " single_accept"}, 32'(l2_req_valid), 32'd0);
    chk({nm, " no_early_resp"}, 32'(resp_valid), 32'd0);
    if (v.wrong_kind) begin
      if (v.op == L2_OP_SC) begin l2_rd_valid = 1'b1; l2_rd_data = 32'h0BAD0BAD; end
      else begin l2_sc_valid = 1'b1; l2_sc_abort = 1'b1; end
      @(negedge clk);
      l2_rd_valid = 1'b0; l2_sc_valid = 1'b0; l2_sc_abort = 1'b0;
      chk({nm, " wrong_kind_ignored"}, 32'(resp_valid), 32'd0);
    end
    if (v.op == L2_OP_SC) begin l2_sc_valid = 1'b1; l2_sc_abort = v.abort; end
    else begin l2_rd_valid = 1'b1; l2_rd_data = v.rdata; end
    @(negedge clk);
    l2_rd_valid = 1'b0; l2_sc_valid = 1'b0; l2_sc_abort = 1'b0; l2_rd_data = '0;
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, " resp_data"}, resp_data, v.exp_resp);
    chk({nm, " req_ready_respond"}, 32'(req_ready), 32'd0);
    @(negedge clk);
    chk({nm, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
    chk({nm, " req_ready_after"}, 32'(req_ready), 32'd1);
  endtask

  task automatic sc_filtered(input string nm, input logic [29:0] a);
    @(negedge clk);
    req_valid = 1'b1; req_op = L2_OP_SC; req_addr = a; req_data = 32'h77;
    @(negedge clk);
    req_valid = 1'b0;
    chk({nm, " no_l2_req"}, 32'(l2_req_valid), 32'd0);
    chk({nm, " resp_valid"}, 32'(resp_valid), 32'd1);
    chk({nm, " resp_data"}, resp_data, 32'd1);
    @(negedge clk);
    chk({nm, " resp_one_cycle"}, 32'(resp_valid), 32'd0);
    chk({nm, " idle_again"}, 32'(req_ready), 32'd1);
    chk({nm, " still_no_l2_req"}, 32'(l2_req_valid), 32'd0);
  endtask

  initial begin
    vec_t v;
    vecs[0] = '{L2_OP_LR,  30'h100,      32'h0,        0, 32'hDEADBEEF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{L2_OP_SC,  30'h100,      32'h5,        0, 32'h0,        1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 32'h0};
    vecs[2] = '{L2_OP_RMW, 30'h200,      32'h12345678, 2, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hCAFEF00D};
    vecs[3] = '{L2_OP_LR,  30'h040,      32'h0,        5, 32'h00000001, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h00000001};
    vecs[4] = '{L2_OP_SC,  30'h040,      32'hA5A5A5A5, 1, 32'h0,        1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1};
    vecs[5] = '{L2_OP_RMW, 30'h3FFFFFFF, 32'hFFFFFFFF, 0, 32'h0,        1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0};

    @(negedge clk);
    @(negedge clk);
    chk("reset req_ready", 32'(req_ready), 32'd1);
    chk("reset l2_req_valid", 32'(l2_req_valid), 32'd0);
    chk("reset resp_valid", 32'(resp_valid), 32'd0);
    chk("reset resp_data", resp_data, 32'd0);
    chk("reset l2_flags", {29'b0, l2_lr, l2_sc, l2_store}, 32'd0);
    rst = 1'b0;

    for (int i = 0; i < 6; i++) run_op($sformatf("vec%0d", i), vecs[i]);

`ifndef L2_SC_LOCAL_FILTER_EN
    // With no shadow, an SC with no prior LR still goes to L2.
    v = '{L2_OP_SC, 30'h104, 32'h9, 0, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1};
    run_op("sc_unreserved", v);
`else
    v = '{L2_OP_LR, 30'h100, 32'h0, 0, 32'h11223344, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h11223344};
    run_op("filt_lr1", v);
    @(negedge clk);
    inv_valid = 1'b1; inv_addr = 30'h100;
    @(negedge clk);
    inv_valid = 1'b0;
    sc_filtered("filt_after_inv", 30'h100);
    run_op("filt_lr2", v);
    sc_filtered("filt_addr_mismatch", 30'h104);
    sc_filtered("filt_after_sc_clear", 30'h100);
    // A non-matching snoop leaves the reservation intact, so this SC goes out.
    run_op("filt_lr3", v);
    @(negedge clk);
    inv_valid = 1'b1; inv_addr = 30'h180;
    @(negedge clk);
    inv_valid = 1'b0;
    v = '{L2_OP_SC, 30'h100, 32'h3, 0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'h0};
    run_op("filt_sc_kept", v);
`endif

    // Reset while waiting for read data abandons the op silently.
    @(negedge clk);
    req_valid = 1'b1; req_op = L2_OP_LR; req_addr = 30'h300; req_data = '0;
    @(negedge clk);
    req_valid = 1'b0; l2_req_ready = 1'b1;
    @(negedge clk);
    l2_req_ready = 1'b0;
    chk("rst_mid wait_state", 32'(l2_req_valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; l2_rd_valid = 1'b1; l2_rd_data = 32'h11111111;
    chk("rst_mid req_ready", 32'(req_ready), 32'd1);
    chk("rst_mid resp_valid", 32'(resp_valid), 32'd0);
    chk("rst_mid l2_lr", 32'(l2_lr), 32'd0);
    chk("rst_mid resp_data", resp_data, 32'd0);
    @(negedge clk);
    l2_rd_valid = 1'b0;
    chk("rst_mid late_rd_ignored", 32'(resp_valid), 32'd0);
    chk("rst_mid still_idle", 32'(req_ready), 32'd1);
    @(negedge clk);
    chk("rst_mid no_resp_later", 32'(resp_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

endmodule
